// File: rtl/btn_counter_pkg.sv
// Shared helpers for the button up/down counter.
// Count limits and register widths derived from parameters.
package btn_counter_pkg;

    // Largest signed value representable in w bits.
    function automatic int cnt_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest signed value representable in w bits.
    function automatic int cnt_min(input int w);
        return -(1 << (w - 1));
    endfunction

    // Width of a stable counter that must reach n.
    function automatic int db_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of a repeat timer that must hold max(d, p).
    function automatic int rpt_w(input int d, input int p);
        return $clog2(((d > p) ? d : p) + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button press qualifier with optional auto-repeat.
// Ports: CLK, RST (sync, active high), BTN raw level,
//        STEP_PULSE one-cycle registered step request.
module btn_debounce
    import btn_counter_pkg::*;
#(
    parameter int DB_CYCLES  = 3,
    parameter int RPT_DELAY  = 0,
    parameter int RPT_PERIOD = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic STEP_PULSE
);

    localparam int DW = db_w(DB_CYCLES);
    localparam int TW = rpt_w(RPT_DELAY, RPT_PERIOD);

    localparam int ARM_I = DB_CYCLES - 1;
    localparam int ONE_I = 1;
    localparam bit RPT_EN = (RPT_DELAY > 0);

    localparam logic [DW-1:0] DB_MAX = DB_CYCLES[DW-1:0];
    localparam logic [DW-1:0] DB_ARM = ARM_I[DW-1:0];
    localparam logic [TW-1:0] T_DLY  = RPT_DELAY[TW-1:0];
    localparam logic [TW-1:0] T_PER  = RPT_PERIOD[TW-1:0];
    localparam logic [TW-1:0] T_ONE  = ONE_I[TW-1:0];

    logic [DW-1:0] stab_q, stab_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        stab_d  = stab_q;
        tmr_d   = tmr_q;
        pulse_d = 1'b0;
        if (!BTN) begin
            stab_d = '0;
            tmr_d  = '0;
        end else if (stab_q != DB_MAX) begin
            stab_d = stab_q + DW'(1);
            // Last qualifying sample: fire and arm the first repeat.
            if (stab_q == DB_ARM) begin
                pulse_d = 1'b1;
                tmr_d   = T_DLY;
            end
        end else if (RPT_EN) begin
            // Timer counts down; reaching one fires and reloads.
            if (tmr_q == T_ONE) begin
                pulse_d = 1'b1;
                tmr_d   = T_PER;
            end else begin
                tmr_d = tmr_q - TW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stab_q  <= '0;
            tmr_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            stab_q  <= stab_d;
            tmr_q   <= tmr_d;
            pulse_q <= pulse_d;
        end
    end

    assign STEP_PULSE = pulse_q;

endmodule

// File: rtl/btn_updown_counter.sv
// Two-button signed up/down counter with saturate/wrap modes.
// Ports: CLK, RST (sync, active high), BTN_E dec, BTN_W inc,
//        CLR sync clear, WRAP_EN mode; CNT count, LED sign-extended
//        count, AT_MAX / AT_MIN limit flags.
module btn_updown_counter
    import btn_counter_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int LED_W      = 8,
    parameter int DB_CYCLES  = 3,
    parameter int STEP       = 1,
    parameter int RPT_DELAY  = 0,
    parameter int RPT_PERIOD = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BTN_E,
    input  logic             BTN_W,
    input  logic             CLR,
    input  logic             WRAP_EN,
    output logic [CNT_W-1:0] CNT,
    output logic [LED_W-1:0] LED,
    output logic             AT_MAX,
    output logic             AT_MIN
);

    localparam int MAX_I = cnt_max(CNT_W);
    localparam int MIN_I = cnt_min(CNT_W);

    localparam logic signed [CNT_W:0] MAX_X  = MAX_I[CNT_W:0];
    localparam logic signed [CNT_W:0] MIN_X  = MIN_I[CNT_W:0];
    localparam logic signed [CNT_W:0] STEP_X = STEP[CNT_W:0];

    localparam logic [CNT_W-1:0] MAX_C = MAX_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] MIN_C = MIN_I[CNT_W-1:0];

    logic                 inc_p, dec_p;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic signed [CNT_W:0] cur_x, sum_x;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .RPT_DELAY (RPT_DELAY),
        .RPT_PERIOD(RPT_PERIOD)
    ) u_db_w (
        .CLK       (CLK),
        .RST       (RST),
        .BTN       (BTN_W),
        .STEP_PULSE(inc_p)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .RPT_DELAY (RPT_DELAY),
        .RPT_PERIOD(RPT_PERIOD)
    ) u_db_e (
        .CLK       (CLK),
        .RST       (RST),
        .BTN       (BTN_E),
        .STEP_PULSE(dec_p)
    );

    always_comb begin
        // One guard bit so overflow is visible before clamping.
        cur_x = {cnt_q[CNT_W-1], cnt_q};
        sum_x = cur_x;
        if (inc_p && !dec_p) begin
            sum_x = cur_x + STEP_X;
        end else if (dec_p && !inc_p) begin
            sum_x = cur_x - STEP_X;
        end

        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (inc_p != dec_p) begin
            if (WRAP_EN) begin
                cnt_d = sum_x[CNT_W-1:0];
            end else if (sum_x > MAX_X) begin
                cnt_d = MAX_C;
            end else if (sum_x < MIN_X) begin
                cnt_d = MIN_C;
            end else begin
                cnt_d = sum_x[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CNT    = cnt_q;
    assign LED    = LED_W'($signed(cnt_q));
    assign AT_MAX = (cnt_q == MAX_C);
    assign AT_MIN = (cnt_q == MIN_C);

endmodule

// File: tb/tb_btn_updown_counter.sv
// Self-checking bench for btn_updown_counter.
// Three instances: defaults, STEP=3, and auto-repeat 10/4.
module tb_btn_updown_counter;

    localparam int DB = 3;
    localparam int RP = 4;
    localparam int STP [3] = '{1, 3, 1};
    localparam int RD  [3] = '{0, 0, 10};

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic btnw [3];
    logic btne [3];
    logic clr  [3];
    logic wrap [3];
    logic [3:0] cnt [3];
    logic [7:0] led [3];
    logic atmax [3];
    logic atmin [3];

    int m_cnt  [3] = '{0, 0, 0};
    int m_runw [3] = '{0, 0, 0};
    int m_rune [3] = '{0, 0, 0};

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    btn_updown_counter #(
        .CNT_W(4), .LED_W(8), .DB_CYCLES(3),
        .STEP(1), .RPT_DELAY(0), .RPT_PERIOD(4)
    ) u0 (
        .CLK(CLK), .RST(RST), .BTN_E(btne[0]), .BTN_W(btnw[0]),
        .CLR(clr[0]), .WRAP_EN(wrap[0]), .CNT(cnt[0]), .LED(led[0]),
        .AT_MAX(atmax[0]), .AT_MIN(atmin[0])
    );

    btn_updown_counter #(
        .CNT_W(4), .LED_W(8), .DB_CYCLES(3),
        .STEP(3), .RPT_DELAY(0), .RPT_PERIOD(4)
    ) u1 (
        .CLK(CLK), .RST(RST), .BTN_E(btne[1]), .BTN_W(btnw[1]),
        .CLR(clr[1]), .WRAP_EN(wrap[1]), .CNT(cnt[1]), .LED(led[1]),
        .AT_MAX(atmax[1]), .AT_MIN(atmin[1])
    );

    btn_updown_counter #(
        .CNT_W(4), .LED_W(8), .DB_CYCLES(3),
        .STEP(1), .RPT_DELAY(10), .RPT_PERIOD(4)
    ) u2 (
        .CLK(CLK), .RST(RST), .BTN_E(btne[2]), .BTN_W(btnw[2]),
        .CLR(clr[2]), .WRAP_EN(wrap[2]), .CNT(cnt[2]), .LED(led[2]),
        .AT_MAX(atmax[2]), .AT_MIN(atmin[2])
    );

    // Reference: l = consecutive high samples ending one edge ago.
    function automatic int due(input int l, input int d);
        if (l == DB) return 1;
        if (d > 0 && l >= DB + d && ((l - DB - d) % RP) == 0) return 1;
        return 0;
    endfunction

    function automatic int arith(input int v, input int dl, input logic wr);
        int s;
        s = v + dl;
        if (wr) begin
            s = (((s + 8) % 16) + 16) % 16;
            return s - 8;
        end
        if (s > 7) return 7;
        if (s < -8) return -8;
        return s;
    endfunction

    function automatic integer sv(input logic [3:0] x);
        sv = $signed(x);
    endfunction

    always @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (RST || clr[i]) begin
                m_cnt[i] <= 0;
            end else begin
                m_cnt[i] <= arith(m_cnt[i],
                    (due(m_runw[i], RD[i]) - due(m_rune[i], RD[i])) * STP[i],
                    wrap[i]);
            end
            m_runw[i] <= (RST || !btnw[i]) ? 0 : m_runw[i] + 1;
            m_rune[i] <= (RST || !btne[i]) ? 0 : m_rune[i] + 1;
        end
    end

    task automatic press(input int i, input bit west, input int hold);
        if (west) btnw[i] = 1'b1;
        else btne[i] = 1'b1;
        repeat (hold) @(negedge CLK);
        btnw[i] = 1'b0;
        btne[i] = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic clear(input int i);
        clr[i] = 1'b1;
        @(negedge CLK);
        clr[i] = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        btnw[0] = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            tests++;
            if (cnt[0] !== 4'd0)
                $display("FAIL reset_hold: got %0d want 0", sv(cnt[0]));
            if (cnt[0] !== 4'd0) fails++;
        end
        RST = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            tests++;
            if (sv(cnt[0]) !== ((k == 4) ? 1 : 0)) begin
                fails++;
                $display("FAIL reset_requal k=%0d: got %0d want %0d",
                         k, sv(cnt[0]), (k == 4) ? 1 : 0);
            end
        end
        repeat (6) @(negedge CLK);
        tests++;
        if (sv(cnt[0]) !== 1 || m_cnt[0] !== 1) begin
            fails++;
            $display("FAIL held_no_repeat: got %0d want 1", sv(cnt[0]));
        end
        btnw[0] = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_bounce();
        clear(0);
        for (int k = 0; k < 18; k++) begin
            btnw[0] = (k % 3 != 2);
            @(negedge CLK);
            tests++;
            if (cnt[0] !== 4'd0 || led[0] !== 8'h00) begin
                fails++;
                $display("FAIL bounce k=%0d: got %0d led %h want 0 led 00",
                         k, sv(cnt[0]), led[0]);
            end
        end
        btnw[0] = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_sat_wrap();
        clear(0);
        wrap[0] = 1'b0;
        repeat (10) press(0, 1'b1, 3);
        tests++;
        if (sv(cnt[0]) !== 7 || led[0] !== 8'h07 || atmax[0] !== 1'b1
            || atmin[0] !== 1'b0) begin
            fails++;
            $display("FAIL saturate_max: got %0d led %h max %b want 7 led 07 max 1",
                     sv(cnt[0]), led[0], atmax[0]);
        end
        wrap[0] = 1'b1;
        press(0, 1'b1, 3);
        tests++;
        if (sv(cnt[0]) !== -8 || led[0] !== 8'hF8 || atmin[0] !== 1'b1
            || atmax[0] !== 1'b0) begin
            fails++;
            $display("FAIL wrap_max: got %0d led %h min %b want -8 led f8 min 1",
                     sv(cnt[0]), led[0], atmin[0]);
        end
        wrap[0] = 1'b0;
    endtask

    task automatic test_step3();
        clear(1);
        wrap[1] = 1'b0;
        repeat (2) press(1, 1'b0, 3);
        tests++;
        if (sv(cnt[1]) !== -6) begin
            fails++;
            $display("FAIL step3_setup: got %0d want -6", sv(cnt[1]));
        end
        press(1, 1'b0, 3);
        tests++;
        if (sv(cnt[1]) !== -8 || atmin[1] !== 1'b1 || m_cnt[1] !== -8) begin
            fails++;
            $display("FAIL step3_clamp: got %0d want -8", sv(cnt[1]));
        end
        clear(1);
        repeat (2) press(1, 1'b0, 3);
        wrap[1] = 1'b1;
        press(1, 1'b0, 3);
        tests++;
        if (sv(cnt[1]) !== 7 || led[1] !== 8'h07) begin
            fails++;
            $display("FAIL step3_wrap: got %0d led %h want 7 led 07",
                     sv(cnt[1]), led[1]);
        end
        wrap[1] = 1'b0;
    endtask

    task automatic test_both_and_clr();
        clear(0);
        repeat (3) press(0, 1'b1, 3);
        btnw[0] = 1'b1;
        btne[0] = 1'b1;
        repeat (4) @(negedge CLK);
        btnw[0] = 1'b0;
        btne[0] = 1'b0;
        repeat (2) @(negedge CLK);
        tests++;
        if (sv(cnt[0]) !== 3) begin
            fails++;
            $display("FAIL both_buttons: got %0d want 3", sv(cnt[0]));
        end
        btnw[0] = 1'b1;
        repeat (3) @(negedge CLK);
        clr[0] = 1'b1;
        @(negedge CLK);
        clr[0] = 1'b0;
        tests++;
        if (sv(cnt[0]) !== 0) begin
            fails++;
            $display("FAIL clr_vs_step: got %0d want 0", sv(cnt[0]));
        end
        repeat (3) @(negedge CLK);
        tests++;
        if (sv(cnt[0]) !== 0) begin
            fails++;
            $display("FAIL clr_after: got %0d want 0", sv(cnt[0]));
        end
        btnw[0] = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_repeat();
        int upd [6] = '{3, 13, 17, 21, 25, 29};
        int want;
        clear(2);
        btnw[2] = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge CLK);
            want = 0;
            for (int j = 0; j < 6; j++)
                if (upd[j] <= n - 1) want++;
            tests++;
            if (sv(cnt[2]) !== want) begin
                fails++;
                $display("FAIL repeat edge t0+%0d: got %0d want %0d",
                         n - 1, sv(cnt[2]), want);
            end
        end
        btnw[2] = 1'b0;
        repeat (2) @(negedge CLK);
        btnw[2] = 1'b1;
        repeat (2) @(negedge CLK);
        btnw[2] = 1'b0;
        repeat (3) @(negedge CLK);
        tests++;
        if (sv(cnt[2]) !== 6) begin
            fails++;
            $display("FAIL repeat_short: got %0d want 6", sv(cnt[2]));
        end
    endtask

    task automatic test_random();
        logic [7:0] el;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 3; i++) begin
                el = 8'(m_cnt[i]);
                tests++;
                if (sv(cnt[i]) !== m_cnt[i] || led[i] !== el
                    || atmax[i] !== (m_cnt[i] == 7)
                    || atmin[i] !== (m_cnt[i] == -8)) begin
                    fails++;
                    $display("FAIL random c=%0d u%0d: got %0d led %h want %0d led %h",
                             c, i, sv(cnt[i]), led[i], m_cnt[i], el);
                end
            end
            RST = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 4) == 0) btnw[i] = ~btnw[i];
                if ($urandom_range(0, 4) == 0) btne[i] = ~btne[i];
                clr[i] = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 7) == 0) wrap[i] = ~wrap[i];
            end
            @(negedge CLK);
        end
        RST = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            btnw[i] = 1'b0;
            btne[i] = 1'b0;
            clr[i]  = 1'b0;
            wrap[i] = 1'b0;
        end
        test_reset();
        test_bounce();
        test_sat_wrap();
        test_step3();
        test_both_and_clr();
        test_repeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
